id_ex_pipeline_register: RTL and testbench
==========================================

Name: id_ex_pipeline_register

Overview:
ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the main control decoder and the register file. It latches the decoder's control bundle, operand data and register specifiers into the EX stage. It also detects load-use hazards, inserts bubbles on hazard or flush, and keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, width of PC+4, register read data and sign-extended immediate
REG_AW, 5, register specifier width
CNT_W, 16, bubble counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
hold  input  1  global freeze (memory wait); register keeps contents
flush  input  1  squash the instruction in ID (taken branch/jump resolved downstream)
id_reg_dst, id_branch_beq, id_branch_bne, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_jump  input  1 each  decoder control outputs
id_alu_op  input  2  decoder ALUOp
id_pc_plus4, id_read_data1, id_read_data2, id_imm_ext  input  DATA_W each  ID-stage data
id_rs, id_rt, id_rd  input  REG_AW each  register specifiers
id_funct  input  6  instruction[5:0]
ex_* (one per id_* above)  output  same widths  registered copies
load_use_stall  output  1  combinational; freezes PC and IF/ID when high
bubble_count  output  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, immediate): every ex_* output = 0, bubble_count = 0. The all-zero control bundle equals the decoder's default/NOP encoding (ALUOp 2'b00).
- rt_used = (!id_alu_src && !id_jump) || id_mem_write. This covers R-type, beq, bne and sw. It excludes addi, andi, lw and j.
- hazard = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (rt_used && ex_rt == id_rt)).
- load_use_stall = hazard && !flush && !hold. It is purely combinational from the current ex_* state and id_* inputs.
- Per rising edge, highest priority first:
  1. hold=1: all ex_* and bubble_count unchanged.
  2. flush=1: bubble.
  3. hazard=1: bubble.
  4. Otherwise load all ex_* from id_*.
- Bubble: all ten control outputs are forced to 0 (ALUOp 2'b00). Data and specifier fields load normally from id_*, which keeps the datapath deterministic. ex_rt is not zeroed, but ex_mem_read=0 prevents any further hazard from it.
- bubble_count increments by 1 on every edge where a bubble is inserted (case 2 or 3). flush and hazard together count once. The counter saturates at all-ones and does not wrap.
- Latency: exactly 1 cycle from id_* to ex_*.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_read=0, so hazard drops while the held ID instruction re-presents.
- Reset asserted mid-stall: outputs clear immediately and load_use_stall deasserts in the same cycle, because ex_mem_read=0.
- No forwarding logic here; the forwarding unit consumes ex_rs and ex_rt.

Decomposition:
- Shared package (mips_pkg):
  - opcode constants (OP_RTYPE 6'b000000, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J)
  - ALUOp encodings (ALUOP_ADD 00, ALUOP_SUB 01, ALUOP_FUNCT 10, ALUOP_AND 11)
  - packed ctrl_bundle_t struct and a CTRL_NOP constant
- One sub-module, load_use_detect: purely combinational, produces hazard and load_use_stall. The register and counter stay in the parent.

Test Plan:
- Reset pulse asynchronous to clk, during a load-use stall -> all ex_* = 0, bubble_count = 0 and load_use_stall = 0 before the next edge.
- lw $8,0($9) then add $10,$8,$11 (id_rs=8) -> load_use_stall=1 for one cycle; the next edge gives all ex_* controls 0 and bubble_count=1; the following edge loads the add with ex_reg_dst=1, ex_alu_op=2'b10.
- lw $8 then sw $8,4($12) (id_rt=8, mem_write=1) -> stall asserted. lw $8 then addi $8,$9,1 (id_rt=8, alu_src=1) -> no stall. lw $0 then add using $0 -> no stall.
- hold=1 and flush=1 together for 3 cycles with changing id_* -> ex_* and bubble_count unchanged, load_use_stall=0.
- flush=1 while a hazard is present -> load_use_stall=0, exactly one bubble, bubble_count increments by 1.
- With CNT_W=4, 20 consecutive flush cycles -> bubble_count saturates at 4'hF and stays there.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALUOp encodings and the decoder control bundle shared by the pipeline.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    typedef struct packed {
        logic       reg_dst;
        logic       branch_beq;
        logic       branch_bne;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_bundle_t;

    // All-zero bundle is the decoder's NOP encoding, so a bubble is just zeros.
    localparam ctrl_bundle_t CTRL_NOP = '{default: '0};
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_alu_src,
    input  logic              id_jump,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              hold,
    output logic              hazard,
    output logic              load_use_stall
);
    logic rt_used;
    // rt is a source for R-type, branches and stores; immediates, loads and jumps ignore it.
    assign rt_used        = (!id_alu_src && !id_jump) || id_mem_write;
    assign hazard         = ex_mem_read && (ex_rt != '0) &&
                            ((ex_rt == id_rs) || (rt_used && (ex_rt == id_rt)));
    assign load_use_stall = hazard && !flush && !hold;
endmodule

// File: rtl/id_ex_pipeline_register.sv
// id_ex_pipeline_register: ID/EX stage register with load-use bubble insertion and a
// saturating bubble counter.
module id_ex_pipeline_register
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_reg_dst,
    input  logic              id_branch_beq,
    input  logic              id_branch_bne,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_jump,
    input  logic [1:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_read_data1,
    input  logic [DATA_W-1:0] id_read_data2,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [5:0]        id_funct,
    output logic              ex_reg_dst,
    output logic              ex_branch_beq,
    output logic              ex_branch_bne,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_jump,
    output logic [1:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_read_data1,
    output logic [DATA_W-1:0] ex_read_data2,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [5:0]        ex_funct,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_count
);
    ctrl_bundle_t id_ctrl, ex_ctrl;
    logic         hazard, bubble;

    assign id_ctrl = '{reg_dst: id_reg_dst, branch_beq: id_branch_beq, branch_bne: id_branch_bne,
                       mem_read: id_mem_read, mem_to_reg: id_mem_to_reg, mem_write: id_mem_write,
                       alu_src: id_alu_src, reg_write: id_reg_write, jump: id_jump,
                       alu_op: id_alu_op};
    assign {ex_reg_dst, ex_branch_beq, ex_branch_bne, ex_mem_read, ex_mem_to_reg,
            ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, ex_alu_op} = ex_ctrl;
    assign bubble = flush || hazard;

    load_use_detect #(.REG_AW(REG_AW)) u_detect (
        .ex_mem_read    (ex_ctrl.mem_read),
        .ex_rt          (ex_rt),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_alu_src     (id_alu_src),
        .id_jump        (id_jump),
        .id_mem_write   (id_mem_write),
        .flush          (flush),
        .hold           (hold),
        .hazard         (hazard),
        .load_use_stall (load_use_stall)
    );

    // Bubbles squash only control; data still loads so the datapath never sees stale values.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ex_ctrl       <= CTRL_NOP;
            ex_pc_plus4   <= '0;
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm_ext    <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_funct      <= '0;
            bubble_count  <= '0;
        end else if (!hold) begin
            ex_ctrl       <= bubble ? CTRL_NOP : id_ctrl;
            ex_pc_plus4   <= id_pc_plus4;
            ex_read_data1 <= id_read_data1;
            ex_read_data2 <= id_read_data2;
            ex_imm_ext    <= id_imm_ext;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_funct      <= id_funct;
            if (bubble && bubble_count != '1)
                bubble_count <= bubble_count + CNT_W'(1);
        end
endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb_id_ex_pipeline_register: directed checks of load-use bubbles, hold/flush priority,
// async reset and counter saturation.
module tb_id_ex_pipeline_register;
    localparam logic [10:0] C_LW   = 11'b0_0_0_1_1_0_1_1_0_00;
    localparam logic [10:0] C_ADD  = 11'b1_0_0_0_0_0_0_1_0_10;
    localparam logic [10:0] C_SW   = 11'b0_0_0_0_0_1_1_0_0_00;
    localparam logic [10:0] C_ADDI = 11'b0_0_0_0_0_0_1_1_0_00;

    logic        clk = 0, reset = 1, hold = 0, flush = 0;
    logic [10:0] id_ctl = '0;
    logic [31:0] id_pc_plus4 = '0, id_read_data1 = '0, id_read_data2 = '0, id_imm_ext = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [5:0]  id_funct = '0;
    logic        ex_reg_dst, ex_branch_beq, ex_branch_bne, ex_mem_read, ex_mem_to_reg;
    logic        ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, load_use_stall;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_funct;
    logic [3:0]  bubble_count;
    logic [10:0] ex_ctl;
    int          checks = 0, errors = 0;
    logic [31:0] exp_pc;

    assign ex_ctl = {ex_reg_dst, ex_branch_beq, ex_branch_bne, ex_mem_read, ex_mem_to_reg,
                     ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, ex_alu_op};

    always #5 clk = ~clk;

    id_ex_pipeline_register #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_reg_dst(id_ctl[10]), .id_branch_beq(id_ctl[9]), .id_branch_bne(id_ctl[8]),
        .id_mem_read(id_ctl[7]), .id_mem_to_reg(id_ctl[6]), .id_mem_write(id_ctl[5]),
        .id_alu_src(id_ctl[4]), .id_reg_write(id_ctl[3]), .id_jump(id_ctl[2]),
        .id_alu_op(id_ctl[1:0]),
        .id_pc_plus4(id_pc_plus4), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
        .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .ex_reg_dst(ex_reg_dst), .ex_branch_beq(ex_branch_beq), .ex_branch_bne(ex_branch_bne),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_jump(ex_jump),
        .ex_alu_op(ex_alu_op),
        .ex_pc_plus4(ex_pc_plus4), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ins(input logic [10:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] pc);
        id_ctl        = ctl;
        id_rs         = rs;
        id_rt         = rt;
        id_rd         = rd;
        id_pc_plus4   = pc;
        id_read_data1 = pc ^ 32'hA5A5_0000;
        id_read_data2 = pc ^ 32'h0000_5A5A;
        id_imm_ext    = {27'd0, rd};
        id_funct      = (ctl == C_ADD) ? 6'h20 : 6'h00;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #3;
        check("reset_ctl", ex_ctl, 0);
        check("reset_pc", ex_pc_plus4, 0);
        check("reset_cnt", bubble_count, 0);
        @(negedge clk);
        reset = 0;
        // lw $8,0($9) ; add $10,$8,$11
        ins(C_LW, 9, 8, 0, 32'h104);
        step();
        check("lw_loaded", ex_ctl, C_LW);
        ins(C_ADD, 8, 11, 10, 32'h108);
        #1 check("lu_stall_rs", load_use_stall, 1);
        step();
        check("bubble_ctl", ex_ctl, 0);
        check("bubble_data", ex_pc_plus4, 32'h108);
        check("bubble_cnt1", bubble_count, 1);
        check("stall_drops", load_use_stall, 0);
        step();
        check("add_loaded", ex_ctl, C_ADD);
        check("add_rd", ex_rd, 10);
        check("cnt_still1", bubble_count, 1);
        // lw $8 ; sw $8,4($12)
        ins(C_LW, 9, 8, 0, 32'h200);
        step();
        ins(C_SW, 12, 8, 0, 32'h204);
        #1 check("lu_stall_sw", load_use_stall, 1);
        step();
        check("sw_bubble_cnt", bubble_count, 2);
        check("sw_bubble_ctl", ex_ctl, 0);
        // lw $8 ; addi $8,$9,1 (rt is a destination, not a source)
        ins(C_LW, 9, 8, 0, 32'h300);
        step();
        ins(C_ADDI, 9, 8, 1, 32'h304);
        #1 check("addi_nostall", load_use_stall, 0);
        step();
        check("addi_loaded", ex_ctl, C_ADDI);
        check("addi_cnt", bubble_count, 2);
        // lw $0 ; add using $0
        ins(C_LW, 9, 0, 0, 32'h400);
        step();
        ins(C_ADD, 0, 0, 10, 32'h404);
        #1 check("zero_nostall", load_use_stall, 0);
        step();
        check("zero_loaded", ex_ctl, C_ADD);
        check("zero_cnt", bubble_count, 2);
        exp_pc = 32'h404;
        // hold wins over flush: nothing moves for three cycles
        hold  = 1;
        flush = 1;
        for (int i = 0; i < 3; i++) begin
            ins(C_LW, 9, 8, 0, 32'h500 + 32'(i * 4));
            #1 check("hold_stall", load_use_stall, 0);
            step();
            check("hold_ctl", ex_ctl, C_ADD);
            check("hold_pc", ex_pc_plus4, exp_pc);
            check("hold_cnt", bubble_count, 2);
        end
        hold  = 0;
        flush = 0;
        // flush with a hazard present counts one bubble
        ins(C_LW, 9, 8, 0, 32'h600);
        step();
        ins(C_ADD, 8, 11, 10, 32'h604);
        flush = 1;
        #1 check("flush_masks_stall", load_use_stall, 0);
        step();
        check("flush_bubble_ctl", ex_ctl, 0);
        check("flush_cnt", bubble_count, 3);
        flush = 0;
        #1 check("post_flush_nostall", load_use_stall, 0);
        step();
        check("post_flush_add", ex_ctl, C_ADD);
        check("post_flush_cnt", bubble_count, 3);
        // async reset in the middle of a stall
        ins(C_LW, 9, 8, 0, 32'h700);
        step();
        ins(C_ADD, 8, 11, 10, 32'h704);
        #1 check("pre_reset_stall", load_use_stall, 1);
        #1 reset = 1;
        #1;
        check("rst_stall", load_use_stall, 0);
        check("rst_ctl", ex_ctl, 0);
        check("rst_pc", ex_pc_plus4, 0);
        check("rst_cnt", bubble_count, 0);
        #1 reset = 0;
        step();
        check("after_rst_add", ex_ctl, C_ADD);
        check("after_rst_cnt", bubble_count, 0);
        // counter saturation
        flush = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 13) check("cnt_14", bubble_count, 14);
        end
        check("cnt_sat", bubble_count, 4'hF);
        flush = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
